// File: rtl/gate_tester_pkg.sv
// gate_tester_pkg -- shared types and constants for the 2-input gate tester.
// Holds the FSM state encoding, the vector/counter widths and a small
// saturating-increment helper for the mismatch counter.
package gate_tester_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    // Number of input vectors of a 2-input gate and the width of one vector
    localparam int NUM_VEC = 4;
    localparam int VEC_W   = 2;

    // Settle counter width; wide enough for SETTLE up to 15
    localparam int CNT_W   = 4;

    // Mismatch counter width and its ceiling (one mismatch per vector at most)
    localparam int ERR_W   = 3;
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(NUM_VEC);

    // Final vector of a sweep
    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

    // Increment that sticks at ERR_MAX instead of wrapping
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (v >= ERR_MAX) begin
            r = ERR_MAX;
        end else begin
            r = v + ERR_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_tester_settle_counter.sv
// settle_counter -- counts idle cycles while a test vector settles through
// the gate under test. Held at zero while clear_i is high; while enable_i is
// high it advances once per cycle and raises tc_o on the last settle cycle,
// so an enable window of exactly LIMIT cycles ends with tc_o.
module settle_counter
    import gate_tester_pkg::*;
#(
    parameter int unsigned LIMIT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count: the current cycle is the last settle cycle
    assign tc_o = enable_i && (cnt_q == TC_VAL);

    // Next count: clear wins, then advance, holding at terminal count
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !tc_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_tester.sv
// gate_tester -- drives all four input vectors {a,b} into a 2-input gate,
// waits SETTLE cycles per vector, samples y and compares it to TRUTH[{a,b}].
// Reports a one-cycle done pulse, pass flag, mismatch count and the first
// failing vector.
//
// Optional feature macro: GATE_TESTER_STOP_ON_FAIL_EN
//   defined   -> the first mismatch ends the sweep immediately
//   undefined -> every vector is always checked
//
// y must already be synchronous to clk; no synchronizer is present.
// SETTLE must be in 1..15.
module gate_tester
    import gate_tester_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] TRUTH  = 4'b1000,
    parameter int unsigned        SETTLE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] fail_vec
);

    state_e           state_q;
    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] ab_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [VEC_W-1:0] fail_q;

    logic             settle_tc;
    logic             settle_clear;
    logic             settle_en;
    logic             mismatch;
    logic             last_check;
    logic [VEC_W-1:0] vec_inc;

    // Settle counting only happens in WAIT; any other state parks it at zero,
    // so every WAIT visit starts from a cleared count.
    assign settle_en    = (state_q == ST_WAIT);
    assign settle_clear = (state_q != ST_WAIT);

    settle_counter #(
        .LIMIT (SETTLE)
    ) u_settle (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (settle_clear),
        .enable_i (settle_en),
        .tc_o     (settle_tc)
    );

    // Compare the gate response against the expected truth-table entry
    assign mismatch = (y != TRUTH[vec_q]);
    assign vec_inc  = vec_q + VEC_W'(1);

    // Decide whether this CHECK ends the sweep
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
    assign last_check = (vec_q == LAST_VEC) || mismatch;
`else
    assign last_check = (vec_q == LAST_VEC);
`endif

    // Sweep controller with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            ab_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        vec_q   <= '0;
                        ab_q    <= '0;
                        err_q   <= '0;
                        fail_q  <= '0;
                        pass_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (settle_tc) begin
                        state_q <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (mismatch) begin
                        err_q <= sat_inc(err_q);
                        // Only the first failing vector of a sweep is kept
                        if (err_q == '0) begin
                            fail_q <= vec_q;
                        end
                    end
                    if (last_check) begin
                        state_q <= ST_FINISH;
                    end else begin
                        vec_q   <= vec_inc;
                        ab_q    <= vec_inc;
                        state_q <= ST_WAIT;
                    end
                end

                ST_FINISH: begin
                    // err_q already includes the final CHECK result here
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    busy_q  <= 1'b0;
                    ab_q    <= '0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a         = ab_q[1];
    assign b         = ab_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_tester.sv
// tb_gate_tester -- scoreboard bench for gate_tester (TRUTH=AND, SETTLE=3).
// The gate under test is modelled in the bench and switched between an ideal
// AND and several faulty gates. Each sweep pushes its hand-computed result
// (done edge, err_count, fail_vec, pass, vector sequence length) into a
// queue; a monitor pops an entry at every done pulse and compares.
module tb_gate_tester;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       y;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [1:0] fail_vec;

    int mode;
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        int         done_edge;
        logic [2:0] err;
        logic [1:0] fail;
        logic       pass;
        int         last;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] seq[$];

    // Hand-computed results per gate mode:
    // 0 ideal AND, 1 stuck-at-0, 2 stuck-at-1, 3 NAND, 4 a&~b
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
    int exp_err_t[5]  = '{0, 1, 1, 1, 1};
    int exp_fail_t[5] = '{0, 3, 0, 0, 2};
    int exp_last_t[5] = '{3, 3, 0, 0, 2};
`else
    int exp_err_t[5]  = '{0, 1, 3, 4, 2};
    int exp_fail_t[5] = '{0, 3, 0, 0, 2};
    int exp_last_t[5] = '{3, 3, 3, 3, 3};
`endif

    gate_tester #(
        .TRUTH  (4'b1000),
        .SETTLE (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .y         (y),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_vec  (fail_vec)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Gate under test model
    always_comb begin
        y = 1'b0;
        case (mode)
            0: y = a & b;
            1: y = 1'b0;
            2: y = 1'b1;
            3: y = ~(a & b);
            4: y = a & ~b;
            default: y = 1'b0;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t make_exp(input int id, input int m, input int k);
        exp_t e;
        e.id        = id;
        e.err       = 3'(exp_err_t[m]);
        e.fail      = 2'(exp_fail_t[m]);
        e.pass      = (exp_err_t[m] == 0);
        e.last      = exp_last_t[m];
        e.done_edge = k + 1 + 4 * (exp_last_t[m] + 1);
        return e;
    endfunction

    // Monitor: records the vector sequence of a sweep and scores every done
    initial begin
        logic       prev_busy;
        logic [1:0] prev_ab;
        exp_t       e;
        prev_busy = 1'b0;
        prev_ab   = 2'b00;
        forever begin
            @(negedge clk);
            if (busy && (!prev_busy || {a, b} != prev_ab)) seq.push_back({a, b});
            prev_busy = busy;
            prev_ab   = {a, b};
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("sweep %0d: done@%0d err_count=%0d fail_vec=%0d pass=%0d nvec=%0d",
                             e.id, cyc, err_count, fail_vec, pass, seq.size());
                    check("done_edge", cyc, e.done_edge);
                    check("err_count", int'(err_count), int'(e.err));
                    check("fail_vec", int'(fail_vec), int'(e.fail));
                    check("pass", int'(pass), int'(e.pass));
                    check("busy_at_done", int'(busy), 0);
                    check("vec_seq_len", seq.size(), e.last + 1);
                    for (int i = 0; i < seq.size() && i <= e.last; i++) begin
                        check("vec_seq", int'(seq[i]), i);
                    end
                end
                seq.delete();
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ab"}, int'({a, b}), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_pass"}, int'(pass), 0);
        check({tag, "_err"}, int'(err_count), 0);
        check({tag, "_fail"}, int'(fail_vec), 0);
    endtask

    // One start pulse, one expected result, then check results are held
    task automatic run_sweep(input int id, input int m);
        int k;
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(negedge clk);
        k     = cyc;
        start = 1'b0;
        sb.push_back(make_exp(id, m, k));
        wait_drain();
        repeat (3) @(negedge clk);
        check("held_err", int'(err_count), exp_err_t[m]);
        check("held_fail", int'(fail_vec), exp_fail_t[m]);
        check("held_pass", int'(pass), int'(exp_err_t[m] == 0));
    endtask

    initial begin
        int k;
        reset = 1'b1;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // Directed sweeps over every gate model
        run_sweep(1, 0);
        run_sweep(2, 1);
        run_sweep(3, 2);
        run_sweep(4, 3);
        run_sweep(5, 4);

        // Reset at edge k+8 aborts the sweep without a done pulse
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        k     = cyc;
        start = 1'b0;
        for (int i = 0; i < 100 && cyc < k + 7; i++) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset = 1'b0;
        seq.delete();
        repeat (25) @(negedge clk);
        check("post_reset_busy", int'(busy), 0);
        run_sweep(6, 0);

        // Start pulsed at k+3 during a sweep is ignored
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        k     = cyc;
        start = 1'b0;
        sb.push_back(make_exp(7, 0, k));
        for (int i = 0; i < 100 && cyc < k + 2; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (25) @(negedge clk);
        check("no_restart_busy", int'(busy), 0);

        // Start held high across FINISH starts a second sweep at k+18
        @(negedge clk);
        mode  = 0;
        start = 1'b1;
        @(negedge clk);
        k     = cyc;
        sb.push_back(make_exp(8, 0, k));
        sb.push_back(make_exp(9, 0, k + 18));
        for (int i = 0; i < 100 && cyc < k + 18; i++) @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);
        check("final_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_tester.md
GATE_TESTER -- requirements
Module: gate_tester

Interface
REQ-001 Parameter TRUTH, default 4'b1000, expected y for input vector {a,b}; bit index = {a,b}, so the default is a 2-input AND.
REQ-002 Parameter SETTLE, default 3, idle cycles between driving a vector and sampling y; legal range 1..15.
REQ-003 clk  input  1  rising-edge system clock; the block has one clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a test sweep; sampled only in IDLE.
REQ-006 y  input  1  output of the gate under test.
REQ-007 a  output  1  gate input a = vec[1].
REQ-008 b  output  1  gate input b = vec[0].
REQ-009 busy  output  1  high while a sweep is in progress (WAIT, CHECK, FINISH).
REQ-010 done  output  1  one-cycle pulse at sweep end.
REQ-011 pass  output  1  1 when the last completed sweep had zero mismatches; held until the next start.
REQ-012 err_count  output  3  mismatch count of the last sweep, 0..4.
REQ-013 fail_vec  output  2  {a,b} of the first mismatch of the last sweep; 0 if none.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, CHECK and FINISH.
REQ-015 IDLE with start=1: vec<=0, settle count<=0, err_count<=0, fail_vec<=0, pass<=0, next state WAIT.
REQ-016 In IDLE, a and b SHALL be 0; in all other states {a,b} SHALL equal vec.
REQ-017 WAIT SHALL last exactly SETTLE cycles, then go to CHECK.
REQ-018 CHECK SHALL sample y once and compare it to TRUTH[vec]; on mismatch, err_count increments.
REQ-019 On the first mismatch of a sweep (err_count==0 before the increment), fail_vec<=vec.
REQ-020 CHECK with vec==3 SHALL go to FINISH; otherwise vec increments and the FSM returns to WAIT with the settle count cleared.
REQ-021 FINISH SHALL last one cycle: done=1, pass<=(err_count==0), next state IDLE.
REQ-022 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+1+4*(SETTLE+1); this is edge k+17 for SETTLE=3.
REQ-023 start while busy SHALL be ignored; start held high in IDLE after FINISH SHALL begin a new sweep.
REQ-024 err_count SHALL saturate at 4 and SHALL NOT wrap.
REQ-025 The y input is assumed synchronous to clk; the block contains no synchronizer.

Reset
REQ-026 reset=1 at a rising edge SHALL force state IDLE, vec=0, a=b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
REQ-027 Reset mid-sweep SHALL abort the sweep with no done pulse; reset has priority over start.

Configuration
REQ-028 Macro GATE_TESTER_STOP_ON_FAIL_EN, when defined: a mismatch in CHECK SHALL go directly to FINISH, leaving err_count=1 and fail_vec = the failing vector.
REQ-029 Macro GATE_TESTER_STOP_ON_FAIL_EN, when undefined: all 4 vectors SHALL always be checked, per REQ-020.

Structure
REQ-030 Package gate_tester_pkg SHALL hold the state encoding typedef, NUM_VEC=4, VEC_W=2 and CNT_W=4.
REQ-031 The settle counter SHALL be a sub-module settle_counter (clear, enable, terminal-count output), instantiated once.

Verification
REQ-032 Ideal AND DUT, TRUTH=4'b1000, SETTLE=3, start pulse -> done at edge k+17, pass=1, err_count=0, fail_vec=0.
REQ-033 y stuck-at-0, TRUTH=4'b1000 -> pass=0, err_count=1, fail_vec=2'b11.
REQ-034 y stuck-at-1, macro undefined -> err_count=3, fail_vec=2'b00, done at k+17; with macro defined -> err_count=1, fail_vec=2'b00, done at k+5.
REQ-035 Reset asserted at edge k+8 of a sweep -> all outputs 0 at the next cycle, no done pulse; a later start runs a full sweep.
REQ-036 start pulsed at k+3 during a sweep -> ignored: exactly one done pulse, no restart, vec sequence 0,1,2,3.
